// File: rtl/chimera_cluster_isolate.sv
// Cluster isolation/drain controller on the narrow AXI master path.
// Closes AW/AR, drains in-flight bursts, gates the cluster clock, and reopens after a settle delay.
package chimera_cluster_isolate_pkg;
    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ax_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        ax_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ax_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic    aw_ready;
        logic    ar_ready;
        logic    w_ready;
        b_chan_t b;
        logic    b_valid;
        r_chan_t r;
        logic    r_valid;
    } axi_resp_t;
endpackage

module chimera_cluster_isolate #(
    parameter type         axi_req_t      = chimera_cluster_isolate_pkg::axi_req_t,
    parameter type         axi_resp_t     = chimera_cluster_isolate_pkg::axi_resp_t,
    parameter int unsigned MaxOutstanding = 8,
    parameter int unsigned ClkEnDelay     = 4
) (
    input  logic      soc_clk_i,
    input  logic      rst_ni,
    input  logic      isolate_i,
    output logic      isolated_o,
    output logic      clk_en_o,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i
);
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam int unsigned SetW = $clog2(ClkEnDelay + 1);
    localparam logic [CntW-1:0] CntMax  = CntW'(MaxOutstanding);
    localparam logic [SetW-1:0] SetLast = SetW'(ClkEnDelay - 1);

    typedef enum logic [1:0] {RUN, DRAIN, ISO, WAKE} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] wr_cnt_q, rd_cnt_q;
    logic [SetW-1:0] settle_q;
    logic            aw_hold_q, ar_hold_q;
    logic            clk_en_q, isolated_q;
    logic            path_open, aw_fwd, ar_fwd, drained;
    logic            aw_hs, ar_hs, b_hs, r_last_hs;

    // An address already presented downstream must stay valid until accepted,
    // so the hold term overrides both the state and the outstanding limit.
    always_comb begin
        path_open = (state_q != ISO);
        aw_fwd    = path_open & (((state_q == RUN) & (wr_cnt_q < CntMax)) | aw_hold_q);
        ar_fwd    = path_open & (((state_q == RUN) & (rd_cnt_q < CntMax)) | ar_hold_q);

        mst_req_o          = slv_req_i;
        mst_req_o.aw_valid = slv_req_i.aw_valid & aw_fwd;
        mst_req_o.ar_valid = slv_req_i.ar_valid & ar_fwd;
        mst_req_o.w_valid  = slv_req_i.w_valid & path_open;
        mst_req_o.b_ready  = slv_req_i.b_ready & path_open;
        mst_req_o.r_ready  = slv_req_i.r_ready & path_open;

        slv_resp_o          = mst_resp_i;
        slv_resp_o.aw_ready = mst_resp_i.aw_ready & aw_fwd;
        slv_resp_o.ar_ready = mst_resp_i.ar_ready & ar_fwd;
        slv_resp_o.w_ready  = mst_resp_i.w_ready & path_open;
        slv_resp_o.b_valid  = mst_resp_i.b_valid & path_open;
        slv_resp_o.r_valid  = mst_resp_i.r_valid & path_open;
    end

    assign aw_hs     = mst_req_o.aw_valid & mst_resp_i.aw_ready;
    assign ar_hs     = mst_req_o.ar_valid & mst_resp_i.ar_ready;
    assign b_hs      = mst_resp_i.b_valid & mst_req_o.b_ready;
    assign r_last_hs = mst_resp_i.r_valid & mst_req_o.r_ready & mst_resp_i.r.last;
    assign drained   = (wr_cnt_q == '0) & (rd_cnt_q == '0) & ~aw_hold_q & ~ar_hold_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (isolate_i) state_d = DRAIN;
            DRAIN:   if (!isolate_i) state_d = RUN;
                     else if (drained) state_d = ISO;
            ISO:     if (!isolate_i) state_d = WAKE;
            WAKE:    if (isolate_i) state_d = ISO;
                     else if (settle_q == SetLast) state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge soc_clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= RUN;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            settle_q   <= '0;
            aw_hold_q  <= 1'b0;
            ar_hold_q  <= 1'b0;
            clk_en_q   <= 1'b1;
            isolated_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            aw_hold_q <= mst_req_o.aw_valid & ~mst_resp_i.aw_ready;
            ar_hold_q <= mst_req_o.ar_valid & ~mst_resp_i.ar_ready;
            if (aw_hs & ~b_hs)      wr_cnt_q <= wr_cnt_q + CntW'(1);
            else if (b_hs & ~aw_hs) wr_cnt_q <= wr_cnt_q - CntW'(1);
            if (ar_hs & ~r_last_hs)      rd_cnt_q <= rd_cnt_q + CntW'(1);
            else if (r_last_hs & ~ar_hs) rd_cnt_q <= rd_cnt_q - CntW'(1);
            // Settle count restarts on every WAKE entry, including a re-wake after ISO.
            settle_q   <= ((state_q == WAKE) && (state_d == WAKE)) ? settle_q + SetW'(1) : '0;
            // Registered from the next state so both flags are valid on the first ISO cycle.
            clk_en_q   <= (state_d != ISO);
            isolated_q <= (state_d == ISO) || (state_d == WAKE);
        end
    end

    assign clk_en_o   = clk_en_q;
    assign isolated_o = isolated_q;

    wr_no_underflow: assert property (@(posedge soc_clk_i) disable iff (!rst_ni)
        !(b_hs && !aw_hs && (wr_cnt_q == '0)));
    rd_no_underflow: assert property (@(posedge soc_clk_i) disable iff (!rst_ni)
        !(r_last_hs && !ar_hs && (rd_cnt_q == '0)));
endmodule

// File: tb/tb_chimera_cluster_isolate.sv
// Bench for chimera_cluster_isolate: RUN-state gating table, directed isolate/release
// sequences, then random traffic against a queue-based reference model.
module tb_chimera_cluster_isolate;
    import chimera_cluster_isolate_pkg::*;

    localparam int MAX_OUT = 8;
    localparam int SETTLE  = 4;

    logic      soc_clk, rst_n, isolate, isolated, clk_en;
    axi_req_t  slv_req, mst_req;
    axi_resp_t slv_resp, mst_resp;
    int        n_checks, n_err;

    chimera_cluster_isolate #(
        .MaxOutstanding(MAX_OUT),
        .ClkEnDelay    (SETTLE)
    ) dut (
        .soc_clk_i (soc_clk),
        .rst_ni    (rst_n),
        .isolate_i (isolate),
        .isolated_o(isolated),
        .clk_en_o  (clk_en),
        .slv_req_i (slv_req),
        .slv_resp_o(slv_resp),
        .mst_req_o (mst_req),
        .mst_resp_i(mst_resp)
    );

    initial soc_clk = 1'b0;
    always #5 soc_clk = ~soc_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge soc_clk);
        #1;
    endtask

    task automatic idle_inputs();
        slv_req  = '0;
        mst_resp = '0;
        isolate  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge soc_clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [9:0] gate_vec();
        return {mst_req.aw_valid, slv_resp.aw_ready, mst_req.ar_valid, slv_resp.ar_ready,
                mst_req.w_valid, slv_resp.w_ready, slv_resp.b_valid, mst_req.b_ready,
                slv_resp.r_valid, mst_req.r_ready};
    endfunction

    // stim: {aw_v, aw_r, ar_v, ar_r, w_v, w_r, b_v, b_r, r_v, r_r, r_last}
    // exp : {mst aw_v, slv aw_r, mst ar_v, slv ar_r, mst w_v, slv w_r, slv b_v, mst b_r, slv r_v, mst r_r}
    typedef struct {
        logic [10:0] stim;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[11];

    task automatic run_table();
        vecs[0]  = '{11'b00000000000, 10'b0000000000};
        vecs[1]  = '{11'b10000000000, 10'b1000000000};
        vecs[2]  = '{11'b11000000000, 10'b1100000000};
        vecs[3]  = '{11'b00000011000, 10'b0000001100};
        vecs[4]  = '{11'b00110000000, 10'b0011000000};
        vecs[5]  = '{11'b00000000110, 10'b0000000011};
        vecs[6]  = '{11'b00000000111, 10'b0000000011};
        vecs[7]  = '{11'b00001000000, 10'b0000100000};
        vecs[8]  = '{11'b00000100000, 10'b0000010000};
        vecs[9]  = '{11'b00000001000, 10'b0000000100};
        vecs[10] = '{11'b01000000000, 10'b0100000000};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            step();
            {slv_req.aw_valid, mst_resp.aw_ready, slv_req.ar_valid, mst_resp.ar_ready,
             slv_req.w_valid, mst_resp.w_ready, mst_resp.b_valid, slv_req.b_ready,
             mst_resp.r_valid, slv_req.r_ready, mst_resp.r.last} = vecs[i].stim;
            #2;
            chk($sformatf("table_%0d", i), gate_vec(), vecs[i].exp);
        end
    endtask

    task automatic run_directed();
        // Idle isolate / release timing
        do_reset();
        #2;
        chk("reset_status", {clk_en, isolated}, 2'b10);
        step(); isolate = 1'b1; #2;
        chk("idle_t0_clk_en", clk_en, 1'b1);
        step(); #2;
        chk("idle_t1_not_iso", isolated, 1'b0);
        step(); #2;
        chk("idle_t2_iso", {isolated, clk_en}, 2'b10);
        step(); step();
        step(); isolate = 1'b0; slv_req.aw_valid = 1'b1; #2;
        chk("idle_t5_closed", mst_req.aw_valid, 1'b0);
        for (int k = 6; k < 10; k++) begin
            step(); #2;
            chk($sformatf("idle_wake_t%0d", k), {isolated, clk_en, mst_req.aw_valid}, 3'b110);
        end
        step(); #2;
        chk("idle_t10_open", {isolated, clk_en, mst_req.aw_valid}, 3'b011);

        // Drain with 3 writes and 2 four-beat reads outstanding
        do_reset();
        slv_req.aw_valid = 1'b1; mst_resp.aw_ready = 1'b1;
        repeat (3) begin #2; chk("drain_aw_issue", slv_resp.aw_ready, 1'b1); step(); end
        slv_req.aw_valid = 1'b0;
        slv_req.ar_valid = 1'b1; slv_req.ar.len = 8'd3; mst_resp.ar_ready = 1'b1;
        repeat (2) begin #2; chk("drain_ar_issue", slv_resp.ar_ready, 1'b1); step(); end
        slv_req.ar_valid = 1'b0; isolate = 1'b1;
        step();
        slv_req.aw_valid = 1'b1; slv_req.ar_valid = 1'b1; #2;
        chk("drain_blocked", gate_vec()[9:6], 4'b0000);
        mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
        repeat (3) begin
            #2; chk("drain_b_phase", {isolated, mst_req.aw_valid, mst_req.ar_valid}, 3'b000); step();
        end
        mst_resp.b_valid = 1'b0;
        mst_resp.r_valid = 1'b1; slv_req.r_ready = 1'b1;
        for (int beat = 0; beat < 8; beat++) begin
            mst_resp.r.last = ((beat % 4) == 3); #2;
            chk("drain_r_phase", {isolated, mst_req.aw_valid, mst_req.ar_valid}, 3'b000);
            step();
        end
        mst_resp.r_valid = 1'b0; #2;
        chk("drain_after_last_r", isolated, 1'b0);
        step();
        slv_req.w_valid = 1'b1; mst_resp.w_ready = 1'b1; mst_resp.b_valid = 1'b1;
        mst_resp.r_valid = 1'b1; #2;
        chk("drain_iso_status", {isolated, clk_en}, 2'b10);
        chk("drain_iso_all_closed", gate_vec(), 10'b0);

        // Held AW across isolate
        do_reset();
        slv_req.aw_valid = 1'b1; #2;
        chk("hold_fwd_run", mst_req.aw_valid, 1'b1);
        step(); isolate = 1'b1; #2;
        chk("hold_fwd_iso_req", mst_req.aw_valid, 1'b1);
        repeat (2) begin step(); #2; chk("hold_fwd_drain", mst_req.aw_valid, 1'b1); end
        mst_resp.aw_ready = 1'b1; #2;
        chk("hold_handshake", {mst_req.aw_valid, slv_resp.aw_ready}, 2'b11);
        step(); slv_req.aw_valid = 1'b0; mst_resp.aw_ready = 1'b0; #2;
        chk("hold_wait_b_0", isolated, 1'b0);
        step(); #2;
        chk("hold_wait_b_1", isolated, 1'b0);
        mst_resp.b_valid = 1'b1; slv_req.b_ready = 1'b1;
        step(); mst_resp.b_valid = 1'b0; #2;
        chk("hold_after_b", isolated, 1'b0);
        step(); #2;
        chk("hold_iso", isolated, 1'b1);

        // Outstanding read limit
        do_reset();
        slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin #2; chk("limit_fill", slv_resp.ar_ready, 1'b1); step(); end
        #2;
        chk("limit_blocked", {mst_req.ar_valid, slv_resp.ar_ready}, 2'b00);
        mst_resp.r_valid = 1'b1; mst_resp.r.last = 1'b1; slv_req.r_ready = 1'b1;
        step(); mst_resp.r_valid = 1'b0; #2;
        chk("limit_reopen", {mst_req.ar_valid, slv_resp.ar_ready}, 2'b11);

        // Aborted drain and re-isolate during WAKE
        do_reset();
        slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
        step(); step();
        slv_req.ar_valid = 1'b0; isolate = 1'b1;
        step(); isolate = 1'b0; #2;
        chk("abort_drain_clk_en", clk_en, 1'b1);
        step(); slv_req.ar_valid = 1'b1; #2;
        chk("abort_run_status", {clk_en, isolated}, 2'b10);
        chk("abort_run_open", mst_req.ar_valid, 1'b1);
        slv_req.ar_valid = 1'b0;
        repeat (3) begin step(); #2; chk("abort_clk_en_held", clk_en, 1'b1); end
        do_reset();
        isolate = 1'b1;
        step(); step(); isolate = 1'b0;
        step(); #2;
        chk("rewake_wake", {clk_en, isolated}, 2'b11);
        step(); isolate = 1'b1;
        step(); #2;
        chk("rewake_iso", {clk_en, isolated}, 2'b01);
        isolate = 1'b0; slv_req.ar_valid = 1'b1;
        repeat (4) begin step(); #2; chk("rewake_settle", {clk_en, mst_req.ar_valid}, 2'b10); end
        step(); #2;
        chk("rewake_open", mst_req.ar_valid, 1'b1);

        // Asynchronous reset in ISO and in a stuck DRAIN
        do_reset();
        isolate = 1'b1;
        step(); step(); #2;
        chk("rst_pre_iso", {clk_en, isolated}, 2'b01);
        rst_n = 1'b0; #1;
        chk("rst_async_iso", {clk_en, isolated}, 2'b10);
        do_reset();
        slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
        repeat (3) step();
        slv_req.ar_valid = 1'b0; isolate = 1'b1;
        step(); step(); #2;
        chk("rst_pre_drain", isolated, 1'b0);
        rst_n = 1'b0; #1;
        chk("rst_async_drain", {clk_en, isolated}, 2'b10);
        do_reset();
        slv_req.ar_valid = 1'b1; mst_resp.ar_ready = 1'b1;
        for (int i = 0; i < MAX_OUT; i++) begin #2; chk("rst_cnt_cleared", slv_resp.ar_ready, 1'b1); step(); end
        #2;
        chk("rst_cnt_limit", slv_resp.ar_ready, 1'b0);
    endtask

    // Reference model: outstanding bursts as queues, mode as a plain label.
    typedef enum int {M_RUN, M_DRAIN, M_ISO, M_WAKE} mode_e;

    task automatic run_random(input int cycles);
        mode_e      mode = M_RUN;
        logic [3:0] wq[$];
        logic [3:0] rq[$];
        bit         aw_stall = 0, ar_stall = 0, aw_wait = 0, ar_wait = 0;
        int         wake_left = 0;
        do_reset();
        for (int c = 0; c < cycles; c++) begin
            bit         closed, aw_go, ar_go, drained, aw_hs, ar_hs, b_hs, r_hs;
            logic [9:0] e;
            step();
            if (!aw_wait) begin
                slv_req.aw_valid = ($urandom_range(0, 2) == 0);
                slv_req.aw.addr  = $urandom;
                slv_req.aw.id    = 4'($urandom);
            end
            if (!ar_wait) begin
                slv_req.ar_valid = ($urandom_range(0, 2) == 0);
                slv_req.ar.addr  = $urandom;
                slv_req.ar.len   = 8'($urandom_range(0, 3));
            end
            slv_req.w_valid    = 1'($urandom_range(0, 1));
            slv_req.w.data     = $urandom;
            slv_req.b_ready    = 1'($urandom_range(0, 1));
            slv_req.r_ready    = 1'($urandom_range(0, 1));
            mst_resp.aw_ready  = 1'($urandom_range(0, 1));
            mst_resp.ar_ready  = 1'($urandom_range(0, 1));
            mst_resp.w_ready   = 1'($urandom_range(0, 1));
            mst_resp.b_valid   = (wq.size() > 0) && ($urandom_range(0, 1) == 1);
            mst_resp.r_valid   = (rq.size() > 0) && ($urandom_range(0, 1) == 1);
            mst_resp.r.last    = 1'($urandom_range(0, 1));
            mst_resp.r.data    = $urandom;
            if ($urandom_range(0, 15) == 0) isolate = ~isolate;
            #2;
            closed = (mode == M_ISO);
            aw_go  = !closed && ((mode == M_RUN && wq.size() < MAX_OUT) || aw_stall);
            ar_go  = !closed && ((mode == M_RUN && rq.size() < MAX_OUT) || ar_stall);
            e = {slv_req.aw_valid && aw_go, mst_resp.aw_ready && aw_go,
                 slv_req.ar_valid && ar_go, mst_resp.ar_ready && ar_go,
                 slv_req.w_valid && !closed, mst_resp.w_ready && !closed,
                 mst_resp.b_valid && !closed, slv_req.b_ready && !closed,
                 mst_resp.r_valid && !closed, slv_req.r_ready && !closed};
            chk("rand_gate", gate_vec(), e);
            chk("rand_status", {clk_en, isolated},
                {mode != M_ISO, (mode == M_ISO) || (mode == M_WAKE)});
            chk("rand_payload",
                {mst_req.aw.addr, mst_req.ar.addr, mst_req.w.data, slv_resp.r.data},
                {slv_req.aw.addr, slv_req.ar.addr, slv_req.w.data, mst_resp.r.data});
            aw_hs   = e[9] && mst_resp.aw_ready;
            ar_hs   = e[7] && mst_resp.ar_ready;
            b_hs    = mst_resp.b_valid && e[2];
            r_hs    = mst_resp.r_valid && e[0] && mst_resp.r.last;
            drained = (wq.size() == 0) && (rq.size() == 0) && !aw_stall && !ar_stall;
            case (mode)
                M_RUN:   if (isolate) mode = M_DRAIN;
                M_DRAIN: if (!isolate) mode = M_RUN; else if (drained) mode = M_ISO;
                M_ISO:   if (!isolate) begin mode = M_WAKE; wake_left = SETTLE; end
                default: if (isolate) mode = M_ISO;
                         else begin wake_left--; if (wake_left == 0) mode = M_RUN; end
            endcase
            if (aw_hs) wq.push_back(slv_req.aw.id);
            if (b_hs) void'(wq.pop_front());
            if (ar_hs) rq.push_back(slv_req.ar.id);
            if (r_hs) void'(rq.pop_front());
            aw_stall = e[9] && !mst_resp.aw_ready;
            ar_stall = e[7] && !mst_resp.ar_ready;
            aw_wait  = slv_req.aw_valid && !e[8];
            ar_wait  = slv_req.ar_valid && !e[6];
        end
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        idle_inputs();
        rst_n = 1'b0;
        run_table();
        run_directed();
        run_random(3000);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
